linear_cost_streamer: RTL

Holds the linear cost terms (r, q, p) produced by the cost-update stage and streams them back out in backward-pass order for the Riccati/backward-recursion block. It is the write-side responder and read-side source for the r/q/p memories: the upstream writer drives `*_wren`/`*_wraddress`/`*_data_in`, and a valid/ready stream delivers p(N-1), then q(k) and r(k) for k = N-2 down to 0.

---
 rtl/linear_cost_streamer.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/linear_cost_streamer.sv
// r/q/p linear-cost term store, streamed out in backward-pass order over valid/ready.
// Optional feature macro: LCS_STREAM_SUM_EN (running wrap-around sum of streamed words).
module linear_cost_streamer #(
  parameter int STATE_DIM  = 12,
  parameter int INPUT_DIM  = 4,
  parameter int HORIZON    = 30,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  r_wren,
  input  logic                  q_wren,
  input  logic                  p_wren,
  input  logic [ADDR_WIDTH-1:0] r_wraddress,
  input  logic [ADDR_WIDTH-1:0] q_wraddress,
  input  logic [ADDR_WIDTH-1:0] p_wraddress,
  input  logic [DATA_WIDTH-1:0] r_data_in,
  input  logic [DATA_WIDTH-1:0] q_data_in,
  input  logic [DATA_WIDTH-1:0] p_data_in,
  input  logic                  start,
  input  logic [31:0]           active_horizon,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            out_kind,
  output logic [7:0]            out_k,
  output logic [7:0]            out_idx,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [DATA_WIDTH-1:0] stream_sum
);
  localparam int R_DEPTH  = HORIZON * INPUT_DIM;
  localparam int QP_DEPTH = HORIZON * STATE_DIM;
  localparam int RA       = $clog2(R_DEPTH);
  localparam int QA       = $clog2(QP_DEPTH);
  localparam logic [1:0] K_P = 2'd0, K_Q = 2'd1, K_R = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_PREFETCH, S_STREAM, S_DONE} state_t;
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [1:0]            kind;
    logic [7:0]            k;
    logic [7:0]            idx;
    logic                  last;
  } beat_t;

  state_t state_q, state_d;
  logic [1:0]  gen_kind_q, gen_kind_d;
  logic [7:0]  gen_k_q, gen_k_d, gen_idx_q, gen_idx_d;
  logic [15:0] gen_rem_q, gen_rem_d;
  logic        rd_vld_q, rd_vld_d;
  beat_t       rd_meta_q, rd_meta_d;
  beat_t [1:0] ent_q, ent_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        error_q, error_d;

  logic [DATA_WIDTH-1:0] r_mem [R_DEPTH];
  logic [DATA_WIDTH-1:0] q_mem [QP_DEPTH];
  logic [DATA_WIDTH-1:0] p_mem [QP_DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_q, q_rd_q, p_rd_q;

  logic                  issue, xfer, out_vld, start_acc;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [7:0]            neff;
  beat_t                 rd_beat, head;

  // Read-first memories; a read is only issued into the memory that owns the current kind.
  always_ff @(posedge clk) begin
    if (r_wren && r_wraddress < ADDR_WIDTH'(R_DEPTH))  r_mem[r_wraddress[RA-1:0]] <= r_data_in;
    if (q_wren && q_wraddress < ADDR_WIDTH'(QP_DEPTH)) q_mem[q_wraddress[QA-1:0]] <= q_data_in;
    if (p_wren && p_wraddress < ADDR_WIDTH'(QP_DEPTH)) p_mem[p_wraddress[QA-1:0]] <= p_data_in;
    if (issue && gen_kind_q == K_R) r_rd_q <= r_mem[rd_addr[RA-1:0]];
    if (issue && gen_kind_q == K_Q) q_rd_q <= q_mem[rd_addr[QA-1:0]];
    if (issue && gen_kind_q == K_P) p_rd_q <= p_mem[rd_addr[QA-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      gen_kind_q <= K_P;
      gen_k_q    <= '0;
      gen_idx_q  <= '0;
      gen_rem_q  <= '0;
      rd_vld_q   <= 1'b0;
      rd_meta_q  <= '0;
      ent_q      <= '0;
      cnt_q      <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      gen_kind_q <= gen_kind_d;
      gen_k_q    <= gen_k_d;
      gen_idx_q  <= gen_idx_d;
      gen_rem_q  <= gen_rem_d;
      rd_vld_q   <= rd_vld_d;
      rd_meta_q  <= rd_meta_d;
      ent_q      <= ent_d;
      cnt_q      <= cnt_d;
      error_q    <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (start) state_d = (active_horizon == 32'd0) ? S_DONE : S_PREFETCH;
      S_PREFETCH: state_d = S_STREAM;
      S_STREAM:   if (xfer && head.last) state_d = S_DONE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    error     = error_q;
    out_valid = out_vld;
    out_data  = out_vld ? head.data : '0;
    out_kind  = out_vld ? head.kind : '0;
    out_k     = out_vld ? head.k    : '0;
    out_idx   = out_vld ? head.idx  : '0;
    out_last  = out_vld && head.last;
  end

  always_comb begin
    rd_beat = rd_meta_q;
    case (rd_meta_q.kind)
      K_P:     rd_beat.data = p_rd_q;
      K_Q:     rd_beat.data = q_rd_q;
      default: rd_beat.data = r_rd_q;
    endcase
    head      = (cnt_q != 2'd0) ? ent_q[0] : rd_beat;
    out_vld   = (cnt_q != 2'd0) || rd_vld_q;
    xfer      = out_vld && out_ready;
    start_acc = (state_q == S_IDLE) && start;
    neff      = (active_horizon > 32'(HORIZON)) ? 8'(HORIZON) : active_horizon[7:0];
    rd_addr   = ADDR_WIDTH'(gen_k_q) * ((gen_kind_q == K_R) ? ADDR_WIDTH'(INPUT_DIM) : ADDR_WIDTH'(STATE_DIM))
              + ADDR_WIDTH'(gen_idx_q);
    // Issue only when the skid buffer can still absorb this read if the sink stalls.
    issue     = (state_q == S_PREFETCH || state_q == S_STREAM) && (gen_rem_q != 16'd0)
              && ((cnt_q == 2'd0) || (cnt_q == 2'd1 && !rd_vld_q));

    gen_kind_d = gen_kind_q;
    gen_k_d    = gen_k_q;
    gen_idx_d  = gen_idx_q;
    gen_rem_d  = gen_rem_q;
    error_d    = start_acc && (active_horizon == 32'd0);
    if (start_acc && active_horizon != 32'd0) begin
      gen_kind_d = K_P;
      gen_k_d    = neff - 8'd1;
      gen_idx_d  = '0;
      gen_rem_d  = 16'(STATE_DIM) + (16'(neff) - 16'd1) * 16'(STATE_DIM + INPUT_DIM);
    end else if (issue) begin
      gen_rem_d = gen_rem_q - 16'd1;
      gen_idx_d = gen_idx_q + 8'd1;
      case (gen_kind_q)
        K_P: if (gen_idx_q == 8'(STATE_DIM - 1)) begin
          gen_kind_d = K_Q; gen_k_d = gen_k_q - 8'd1; gen_idx_d = '0;
        end
        K_Q: if (gen_idx_q == 8'(STATE_DIM - 1)) begin
          gen_kind_d = K_R; gen_idx_d = '0;
        end
        default: if (gen_idx_q == 8'(INPUT_DIM - 1)) begin
          gen_kind_d = K_Q; gen_k_d = gen_k_q - 8'd1; gen_idx_d = '0;
        end
      endcase
    end

    rd_vld_d  = issue;
    rd_meta_d = rd_meta_q;
    if (issue) rd_meta_d = '{data: '0, kind: gen_kind_q, k: gen_k_q, idx: gen_idx_q,
                             last: (gen_rem_q == 16'd1)};

    // Read data bypasses the buffer when it is empty and the sink takes it directly.
    ent_d = ent_q;
    cnt_d = cnt_q;
    if (xfer && cnt_q != 2'd0) begin
      ent_d[0] = ent_q[1];
      cnt_d    = cnt_q - 2'd1;
    end
    if (rd_vld_q && !(xfer && cnt_q == 2'd0)) begin
      if (cnt_d == 2'd0) ent_d[0] = rd_beat;
      else               ent_d[1] = rd_beat;
      cnt_d = cnt_d + 2'd1;
    end
  end

`ifdef LCS_STREAM_SUM_EN
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
  always_comb begin
    sum_d = sum_q;
    if (start_acc)  sum_d = '0;
    else if (xfer)  sum_d = sum_q + head.data;
  end
  always_ff @(posedge clk) begin
    if (rst) sum_q <= '0;
    else     sum_q <= sum_d;
  end
  assign stream_sum = sum_q;
`else
  assign stream_sum = '0;
`endif
endmodule
